mod12_ctrl: RTL and testbench

Command scheduler that shares one `mod12` up/down counter between `NREQ` requesters. Each requester issues LOAD, COUNT_UP, COUNT_DOWN or READ commands over a valid/ready handshake. The block arbitrates round-robin, sequences the counter's `load`/`updown`/`d_in` pins for the required number of cycles, and returns a completion pulse carrying the final count. Between commands it holds the counter by reloading its own output.

---
 rtl/mod_pkg.sv | 26 ++
 rtl/mod12_rr_arb.sv | 40 ++++
 rtl/mod12_ctrl.sv | 132 +++++++++++++
 tb/tb_mod12_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mod_pkg.sv
// Shared types and constants for the mod-12 counter scheduler.
package mod_pkg;

  localparam int MOD_N = 12;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_UP   = 2'd1,
    OP_DOWN = 2'd2,
    OP_READ = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Value the shared counter reaches after one counting cycle.
  function automatic logic [CNT_W-1:0] mod_step(input logic [CNT_W-1:0] v, input logic up);
    if (up) return (v == CNT_W'(MOD_N-1)) ? '0 : v + CNT_W'(1);
    else    return (v == '0) ? CNT_W'(MOD_N-1) : v - CNT_W'(1);
  endfunction

endpackage

// File: rtl/mod12_rr_arb.sv
// Round-robin arbiter: combinational winner, pointer remembers last grant.
module mod12_rr_arb #(
  parameter  int NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_accept,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  logic [IDW-1:0] r_ptr;

  // First requester found searching upward from the one after the last grant.
  always_comb begin
    int j;
    j       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      j = (int'(r_ptr) + k) % NREQ;
      if (!o_any && i_req[j]) begin
        o_any      = 1'b1;
        o_idx      = IDW'(j);
        o_grant[j] = 1'b1;
      end
    end
  end

  // Pointer moves only when the grant is actually taken; reset favours index 0.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n)      r_ptr <= IDW'(NREQ-1);
    else if (i_accept) r_ptr <= o_idx;
  end

endmodule

// File: rtl/mod12_ctrl.sv
// Command scheduler sharing one mod-12 up/down counter between requesters.
module mod12_ctrl
  import mod_pkg::*;
#(
  parameter  int NREQ   = 2,
  parameter  int STEP_W = 8,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [2*NREQ-1:0]      req_op,
  input  logic [CNT_W*NREQ-1:0]  req_val,
  input  logic [STEP_W*NREQ-1:0] req_steps,
  output logic                   cnt_load,
  output logic                   cnt_updown,
  output logic [CNT_W-1:0]       cnt_din,
  input  logic [CNT_W-1:0]       cnt_dout,
  output logic                   busy,
  output logic                   done,
  output logic [IDW-1:0]         done_id,
  output logic [CNT_W-1:0]       result,
  output logic                   err
);

  state_e            r_state, w_nxt;
  logic [NREQ-1:0]   w_grant;
  logic [IDW-1:0]    w_idx, r_id;
  logic              w_any, w_accept, w_bad, w_count;
  op_e               w_op, r_op, w_cur_op;
  logic [CNT_W-1:0]  w_val, r_val, w_cur_val, w_cnt_next;
  logic [STEP_W-1:0] w_steps, r_steps;
  logic              r_cnt_load, r_cnt_updown, r_err;
  logic [CNT_W-1:0]  r_cnt_din, r_result;
  logic [IDW-1:0]    r_done_id;

  mod12_rr_arb #(.NREQ(NREQ)) u_arb (
    .i_clk    (clock),
    .i_rst_n  (rst),
    .i_req    (req_valid),
    .i_accept (w_accept),
    .o_grant  (w_grant),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  assign w_accept  = w_any && rst && (r_state == S_IDLE);
  assign req_ready = w_accept ? w_grant : '0;

  assign w_op    = op_e'(req_op[2*int'(w_idx) +: 2]);
  assign w_val   = req_val[CNT_W*int'(w_idx) +: CNT_W];
  assign w_steps = req_steps[STEP_W*int'(w_idx) +: STEP_W];
  assign w_bad   = w_accept && (w_op == OP_LOAD) && (w_val >= CNT_W'(MOD_N));

  // Command in force next cycle: fresh payload on the accept cycle, else latched.
  assign w_cur_op  = w_accept ? w_op  : r_op;
  assign w_cur_val = w_accept ? w_val : r_val;
  assign w_count   = (w_nxt == S_EXEC) && (w_cur_op == OP_UP || w_cur_op == OP_DOWN);

  // Counter value after this edge, from the pins we are driving it with now.
  // Reloading this keeps the hold exact even right after a counting cycle.
  assign w_cnt_next = r_cnt_load ? r_cnt_din : mod_step(cnt_dout, r_cnt_updown);

  // State register.
  always_ff @(posedge clock) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_nxt;
  end

  // Next state: trivial commands skip EXEC; UP/DOWN leave when one step remains.
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) begin
        if (w_op == OP_READ || w_bad || (w_op != OP_LOAD && w_steps == '0)) w_nxt = S_DONE;
        else                                                                   w_nxt = S_EXEC;
      end
      S_EXEC:  if (r_op == OP_LOAD || r_steps == STEP_W'(1)) w_nxt = S_DONE;
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Latch the accepted command; step counter runs down while executing.
  always_ff @(posedge clock) begin
    if (!rst) begin
      r_op    <= OP_LOAD;
      r_val   <= '0;
      r_steps <= '0;
      r_id    <= '0;
    end else if (w_accept) begin
      r_op    <= w_op;
      r_val   <= w_val;
      r_steps <= w_steps;
      r_id    <= w_idx;
    end else if (r_state == S_EXEC) begin
      r_steps <= r_steps - STEP_W'(1);
    end
  end

  // Registered counter pins and completion fields, computed for the next state.
  always_ff @(posedge clock) begin
    if (!rst) begin
      r_cnt_load   <= 1'b0;
      r_cnt_updown <= 1'b0;
      r_cnt_din    <= '0;
      r_result     <= '0;
      r_done_id    <= '0;
      r_err        <= 1'b0;
    end else begin
      r_cnt_load   <= !w_count;
      r_cnt_updown <= w_count && (w_cur_op == OP_UP);
      r_cnt_din    <= (w_nxt == S_EXEC && w_cur_op == OP_LOAD) ? w_cur_val : w_cnt_next;
      if (w_nxt == S_DONE) begin
        r_result  <= w_cnt_next;
        r_done_id <= w_accept ? w_idx : r_id;
        r_err     <= w_bad;
      end
    end
  end

  assign cnt_load   = r_cnt_load;
  assign cnt_updown = r_cnt_updown;
  assign cnt_din    = r_cnt_din;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign done_id    = r_done_id;
  assign result     = r_result;
  assign err        = r_err;

endmodule

// File: tb/tb_mod12_ctrl.sv
// Randomised scoreboard bench for mod12_ctrl driving a behavioural mod-12 counter.
module tb_mod12_ctrl;
  localparam int NREQ = 2;
  localparam int STEP_W = 8;
  localparam int IDW = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NREQ-1:0]        req_valid, req_ready;
  logic [2*NREQ-1:0]      req_op;
  logic [4*NREQ-1:0]      req_val;
  logic [STEP_W*NREQ-1:0] req_steps;
  logic                   cnt_load, cnt_updown, busy, done, err;
  logic [3:0]             cnt_din, cnt, result;
  logic [IDW-1:0]         done_id;

  mod12_ctrl #(.NREQ(NREQ), .STEP_W(STEP_W)) dut (
    .clock(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_val(req_val), .req_steps(req_steps),
    .cnt_load(cnt_load), .cnt_updown(cnt_updown), .cnt_din(cnt_din), .cnt_dout(cnt),
    .busy(busy), .done(done), .done_id(done_id), .result(result), .err(err)
  );

  // The shared counter itself (external plant).
  always @(posedge clk) begin
    if (!rst)            cnt <= 4'd0;
    else if (cnt_load)   cnt <= cnt_din;
    else if (cnt_updown) cnt <= (cnt == 4'd11) ? 4'd0 : 4'(cnt + 4'd1);
    else                 cnt <= (cnt == 4'd0) ? 4'd11 : 4'(cnt - 4'd1);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
  endtask

  typedef struct { int id; int res; int err; bit chk; int due; } exp_t;
  exp_t sb[$];
  exp_t e;
  int acc_cnt[NREQ];
  int seen[NREQ];
  int mptr, m, free_at, lat, a, op, val, stp, experr;
  bit known;
  logic [NREQ-1:0] exp_rdy;

  // Reference model + scoreboard: predicts grants, pushes expectations, checks completions.
  always begin
    @(negedge clk); #2;
    if (!rst) begin
      sb.delete(); mptr = NREQ-1; known = 0; free_at = cyc + 1;
    end else begin
      exp_rdy = '0;
      if (cyc >= free_at)
        for (int k = 1; k <= NREQ; k++)
          if (exp_rdy == '0 && req_valid[(mptr+k)%NREQ]) exp_rdy[(mptr+k)%NREQ] = 1'b1;
      if (req_valid != '0 || req_ready != '0) check("grant", int'(req_ready), int'(exp_rdy));
      if (req_ready != '0) begin
        a = req_ready[0] ? 0 : 1;
        op = int'(req_op[2*a +: 2]); val = int'(req_val[4*a +: 4]); stp = int'(req_steps[STEP_W*a +: STEP_W]);
        experr = 0;
        case (op)
          0: if (val < 12) begin m = val; known = 1; lat = 2; end else begin experr = 1; lat = 1; end
          1: begin m = (m + stp) % 12; lat = (stp == 0) ? 1 : stp + 1; end
          2: begin m = (m + 12 - (stp % 12)) % 12; lat = (stp == 0) ? 1 : stp + 1; end
          default: lat = 1;
        endcase
        sb.push_back('{a, m, experr, known, cyc + lat});
        free_at = cyc + lat + 1; mptr = a; acc_cnt[a]++;
      end
      if (done) begin
        if (sb.size() == 0) check("unexpected_done", int'(done), 0);
        else begin
          e = sb.pop_front();
          check("done_cycle", cyc, e.due);
          check("done_id", int'(done_id), e.id);
          if (e.chk) check("result", int'(result), e.res);
          check("err", int'(err), e.err);
        end
      end else if (sb.size() != 0 && cyc > sb[0].due) begin
        check("done_late", cyc, sb[0].due);
        void'(sb.pop_front());
      end
      if (busy) check("ready_in_busy", int'(req_ready), 0);
    end
  end

  task automatic present(input int i, input int o, input int v, input int s);
    req_op[2*i +: 2] = 2'(o);
    req_val[4*i +: 4] = 4'(v);
    req_steps[STEP_W*i +: STEP_W] = STEP_W'(s);
    req_valid[i] = 1'b1;
  endtask

  // Drop each valid once taken; optionally change payload of waiting requesters.
  task automatic drain(input bit mut);
    for (int k = 0; k < 3000 && req_valid != '0; k++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++)
        if (acc_cnt[i] != seen[i]) begin seen[i] = acc_cnt[i]; req_valid[i] = 1'b0; end
        else if (mut && req_valid[i] && $urandom_range(0, 3) == 0)
          present(i, $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 12));
    end
    if (req_valid != '0) begin check("accept_timeout", int'(req_valid), 0); req_valid = '0; end
  endtask

  task automatic send(input int i, input int o, input int v, input int s);
    present(i, o, v, s);
    drain(1'b0);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy) break;
    end
    if (sb.size() != 0) check("idle_timeout", sb.size(), 0);
  endtask

  initial begin
    int g0, g1;
    req_valid = '0; req_op = '0; req_val = '0; req_steps = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", int'(req_ready), 0);
    check("rst_cnt_load", int'(cnt_load), 0);
    check("rst_updown", int'(cnt_updown), 0);
    check("rst_din", int'(cnt_din), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_result", int'(result) + int'(done_id) + int'(err), 0);
    rst = 1'b1;

    send(0, 0, 5, 0);
    check("load_pin", int'(cnt_load), 1);
    check("load_din", int'(cnt_din), 5);
    wait_idle();

    send(0, 0, 10, 0); send(0, 1, 0, 3); wait_idle();
    check("up_wrap_cnt", int'(cnt), 1);

    send(0, 0, 1, 0); send(0, 2, 0, 3); wait_idle();
    for (int k = 0; k < 5; k++) begin @(negedge clk); check("hold_cnt", int'(cnt), 10); end

    // Both requesters stream READs; grants must alternate.
    g0 = acc_cnt[0]; g1 = acc_cnt[1];
    present(0, 3, 0, 0); present(1, 3, 0, 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) seen[i] = acc_cnt[i];
    end
    req_valid = '0;
    g0 = acc_cnt[0] - g0; g1 = acc_cnt[1] - g1;
    check("rr_balance", int'((g0 - g1) >= -1 && (g0 - g1) <= 1 && g0 >= 4), 1);
    wait_idle();

    send(1, 0, 12, 0); send(0, 1, 0, 0); wait_idle();
    check("bad_load_cnt", int'(cnt), 10);

    // Long UP interrupted by reset.
    send(0, 1, 0, 200);
    repeat (49) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    present(0, 3, 0, 0); present(1, 3, 0, 0);
    rst = 1'b1;
    #1 check("post_rst_ready", int'(req_ready), 1);
    drain(1'b0); wait_idle();
    send(1, 0, 7, 0); wait_idle();

    for (int it = 0; it < 60; it++) begin
      int mask;
      mask = $urandom_range(1, 3);
      for (int i = 0; i < NREQ; i++)
        if (mask[i]) present(i, $urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 12));
      drain(1'b1);
      if ($urandom_range(0, 3) == 0) wait_idle();
    end
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog");
  end

endmodule
